// File: rtl/lane_adder_array_acc.sv
// lane_adder_array_acc: LANES unsigned adders with pass/accumulate modes behind a valid/ready handshake.
// Define LANE_ADDER_STAT_EN to add the o_group_count consumed-result counter.
module lane_adder_array_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES = 8,
  parameter int ACC_LEN = 4,
  localparam int OUT_W = DATA_WIDTH + 1 + $clog2(ACC_LEN),
  localparam int CW = $clog2(ACC_LEN) + 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic                        i_mode,
  input  logic                        i_flush,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] i_num_1,
  input  logic [LANES*DATA_WIDTH-1:0] i_num_2,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [LANES*OUT_W-1:0]      o_out_num,
`ifdef LANE_ADDER_STAT_EN
  output logic [15:0]                 o_group_count,
`endif
  output logic [CW-1:0]               o_out_beats
);
  typedef enum logic {S_IDLE, S_ACC} state_t;
  state_t r_state, w_state_n;
  logic [LANES*OUT_W-1:0] r_acc, w_acc_n, w_sum, w_acc_sum, w_emit_num, r_out_num;
  logic [CW-1:0] r_cnt, w_cnt_n, w_cnt_inc, w_emit_beats, r_out_beats;
  logic r_out_valid, w_room, w_accept, w_consume, w_emit;
  assign w_room = i_enable & (~r_out_valid | i_out_ready);
  assign o_in_ready = i_rst_n & w_room;
  assign w_accept = i_in_valid & o_in_ready;
  assign w_consume = r_out_valid & i_out_ready & i_enable;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign o_out_valid = r_out_valid;
  assign o_out_num = r_out_num;
  assign o_out_beats = r_out_beats;
  always_comb begin
    w_sum = '0;
    w_acc_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum[i*OUT_W +: OUT_W] = OUT_W'(i_num_1[i*DATA_WIDTH +: DATA_WIDTH]) + OUT_W'(i_num_2[i*DATA_WIDTH +: DATA_WIDTH]);
      w_acc_sum[i*OUT_W +: OUT_W] = r_acc[i*OUT_W +: OUT_W] + w_sum[i*OUT_W +: OUT_W];
    end
  end
  // A flush without a beat only closes the group once the output register has room.
  always_comb begin
    w_state_n = r_state;
    w_acc_n = r_acc;
    w_cnt_n = r_cnt;
    w_emit = 1'b0;
    w_emit_num = w_sum;
    w_emit_beats = CW'(1);
    if (r_state == S_IDLE) begin
      if (w_accept && (!i_mode || i_flush)) begin
        w_emit = 1'b1;
      end else if (w_accept) begin
        w_acc_n = w_sum;
        w_cnt_n = CW'(1);
        w_state_n = S_ACC;
      end
    end else if (w_accept) begin
      w_acc_n = w_acc_sum;
      w_cnt_n = w_cnt_inc;
      if (w_cnt_inc == CW'(ACC_LEN) || i_flush) begin
        w_emit = 1'b1;
        w_emit_num = w_acc_sum;
        w_emit_beats = w_cnt_inc;
        w_state_n = S_IDLE;
      end
    end else if (i_flush && w_room) begin
      w_emit = 1'b1;
      w_emit_num = r_acc;
      w_emit_beats = r_cnt;
      w_state_n = S_IDLE;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc <= '0;
      r_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_num <= '0;
      r_out_beats <= '0;
    end else begin
      r_state <= w_state_n;
      r_acc <= w_acc_n;
      r_cnt <= w_cnt_n;
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_num <= w_emit_num;
        r_out_beats <= w_emit_beats;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end
`ifdef LANE_ADDER_STAT_EN
  logic [15:0] r_group_count;
  assign o_group_count = r_group_count;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_group_count <= '0;
    else if (w_consume) r_group_count <= r_group_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_lane_adder_array_acc.sv
// tb_lane_adder_array_acc: scoreboard bench for lane_adder_array_acc in pass, accumulate and flush modes.
module tb_lane_adder_array_acc;
  localparam int DW = 16;
  localparam int L = 8;
  localparam int AL = 4;
  localparam int OW = DW + 1 + $clog2(AL);
  localparam int CW = $clog2(AL) + 1;
  typedef struct packed {
    logic [L*OW-1:0] num;
    logic [CW-1:0] beats;
  } res_t;
  logic clk = 0, rst_n = 1, enable = 0, mode = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [L*DW-1:0] num_1 = '0, num_2 = '0;
  logic in_ready, out_valid;
  logic [L*OW-1:0] out_num;
  logic [CW-1:0] out_beats;
  int total = 0, bad = 0, consumed = 0;
  res_t q[$];
  logic [OW-1:0] m_acc [L];
  int m_cnt = 0;
  bit m_in_acc = 0;
  bit hold = 0;
  logic [L*OW-1:0] h_num;
  logic [CW-1:0] h_beats;
`ifdef LANE_ADDER_STAT_EN
  logic [15:0] group_count;
`endif

  lane_adder_array_acc #(.DATA_WIDTH(DW), .LANES(L), .ACC_LEN(AL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mode(mode), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_num_1(num_1), .i_num_2(num_2),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_num(out_num),
`ifdef LANE_ADDER_STAT_EN
    .o_group_count(group_count),
`endif
    .o_out_beats(out_beats));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      hold = 0;
    end else begin
      if (hold) begin
        total++;
        if (out_num !== h_num || out_beats !== h_beats) begin
          bad++;
          $display("FAIL hold_stable got %h/%0d need %h/%0d", out_num, out_beats, h_num, h_beats);
        end
      end
      total++;
      if (in_ready !== (enable & (~out_valid | out_ready))) begin
        bad++;
        $display("FAIL in_ready got %b need %b", in_ready, enable & (~out_valid | out_ready));
      end
      if (out_valid && out_ready && enable) begin
        consumed++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result got %h/%0d need none", out_num, out_beats);
        end else begin
          e = q.pop_front();
          if (out_num !== e.num || out_beats !== e.beats) begin
            bad++;
            $display("FAIL result got %h/%0d need %h/%0d", out_num, out_beats, e.num, e.beats);
          end
        end
      end
      hold = out_valid && !(out_ready && enable);
      h_num = out_num;
      h_beats = out_beats;
    end
  end

  function automatic logic [OW-1:0] lane_sum(int i);
    return OW'(num_1[i*DW +: DW]) + OW'(num_2[i*DW +: DW]);
  endfunction

  task automatic push_acc();
    res_t r;
    for (int i = 0; i < L; i++) r.num[i*OW +: OW] = m_acc[i];
    r.beats = CW'(m_cnt);
    q.push_back(r);
    m_in_acc = 0;
  endtask

  task automatic model_accept();
    if (!m_in_acc && (!mode || flush)) begin
      for (int i = 0; i < L; i++) m_acc[i] = lane_sum(i);
      m_cnt = 1;
      push_acc();
    end else if (!m_in_acc) begin
      for (int i = 0; i < L; i++) m_acc[i] = lane_sum(i);
      m_cnt = 1;
      m_in_acc = 1;
    end else begin
      for (int i = 0; i < L; i++) m_acc[i] = m_acc[i] + lane_sum(i);
      m_cnt++;
      if (m_cnt == AL || flush) push_acc();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit md, input bit fl, input logic [L*DW-1:0] a, input logic [L*DW-1:0] b);
    int k = 0;
    num_1 = a; num_2 = b; mode = md; flush = fl; in_valid = 1;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL beat_timeout got in_ready=0 need 1");
    end else model_accept();
    @(posedge clk);
    #1;
    in_valid = 0; flush = 0;
  endtask

  task automatic flush_only();
    int k = 0;
    flush = 1; in_valid = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL flush_timeout got room=0 need 1");
    end else if (m_in_acc) push_acc();
    @(posedge clk);
    #1;
    flush = 0;
  endtask

  function automatic logic [L*DW-1:0] rnd();
    logic [L*DW-1:0] v;
    for (int i = 0; i < L; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    enable = 1;
    #2 rst_n = 0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_beats !== '0 || out_num !== '0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset got v=%b b=%0d n=%h r=%b need 0/0/0/0", out_valid, out_beats, out_num, in_ready);
    end
    m_in_acc = 0;
    @(negedge clk) rst_n = 1;
    idle(1);
  endtask

  task automatic test_pass();
    logic [L*DW-1:0] a, b;
    out_ready = 1;
    a = rnd(); b = rnd();
    a[DW-1:0] = 16'hFFFF; b[DW-1:0] = 16'h0001;
    beat(0, 0, a, b);
    total++;
    if (out_valid !== 1'b1 || out_num[OW-1:0] !== 19'h10000 || out_beats !== CW'(1)) begin
      bad++;
      $display("FAIL pass_lane0 got v=%b n=%h b=%0d need 1/10000/1", out_valid, out_num[OW-1:0], out_beats);
    end
    idle(1);
    for (int n = 0; n < 3; n++) begin
      beat(0, 0, rnd(), rnd());
      idle(1);
    end
  endtask

  task automatic test_accumulate();
    out_ready = 1;
    for (int n = 0; n < AL; n++) begin
      beat(1, 0, {L{16'h0003}}, {L{16'h0002}});
      total++;
      if (n < AL - 1 && out_valid !== 1'b0) begin
        bad++;
        $display("FAIL acc_no_early got out_valid=%b need 0 at beat %0d", out_valid, n + 1);
      end else if (n == AL - 1 && (out_valid !== 1'b1 || out_num !== {L{19'd20}} || out_beats !== CW'(AL))) begin
        bad++;
        $display("FAIL acc_sum got v=%b n=%h b=%0d need 1/%h/%0d", out_valid, out_num, out_beats, {L{19'd20}}, AL);
      end
    end
    idle(1);
    beat(1, 0, rnd(), rnd());
    beat(0, 0, rnd(), rnd());
    beat(0, 0, rnd(), rnd());
    beat(1, 0, rnd(), rnd());
    idle(1);
  endtask

  task automatic test_flush();
    out_ready = 1;
    beat(1, 0, {L{16'hFFFF}}, {L{16'hFFFF}});
    beat(1, 0, {L{16'hFFFF}}, {L{16'hFFFF}});
    flush_only();
    total++;
    if (out_valid !== 1'b1 || out_num[OW-1:0] !== 19'h3FFFC || out_beats !== CW'(2)) begin
      bad++;
      $display("FAIL flush_two got v=%b n=%h b=%0d need 1/3fffc/2", out_valid, out_num[OW-1:0], out_beats);
    end
    idle(1);
    beat(1, 1, rnd(), rnd());
    idle(1);
    beat(1, 0, rnd(), rnd());
    beat(0, 1, rnd(), rnd());
    idle(1);
    flush_only();
    flush_only();
    idle(1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_flush got out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    logic [L*OW-1:0] held;
    out_ready = 0;
    beat(0, 0, rnd(), rnd());
    held = out_num;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_num !== held) begin
        bad++;
        $display("FAIL backpressure got r=%b v=%b n=%h need 0/1/%h", in_ready, out_valid, out_num, held);
      end
    end
    idle(1);
    out_ready = 1;
    t0 = $time;
    for (int n = 0; n < 8; n++) beat(0, 0, rnd(), rnd());
    total++;
    if ($time - t0 != 80 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL throughput got %0t v=%b need 80 v=1", $time - t0, out_valid);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    for (int n = 0; n < 3; n++) beat(1, 0, rnd(), rnd());
    #2 rst_n = 0;
    m_in_acc = 0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_num !== '0 || out_beats !== '0) begin
      bad++;
      $display("FAIL reset_mid got v=%b n=%h b=%0d need 0/0/0", out_valid, out_num, out_beats);
    end
    @(negedge clk) rst_n = 1;
    idle(1);
    beat(1, 0, {L{16'h0001}}, {L{16'h0001}});
    beat(1, 0, {L{16'h0001}}, {L{16'h0001}});
    flush_only();
    total++;
    if (out_num !== {L{19'd4}} || out_beats !== CW'(2)) begin
      bad++;
      $display("FAIL reset_fresh got n=%h b=%0d need %h/2", out_num, out_beats, {L{19'd4}});
    end
    idle(1);
  endtask

  task automatic test_enable();
    int c0;
`ifdef LANE_ADDER_STAT_EN
    logic [15:0] g0;
`endif
    out_ready = 0;
    beat(0, 0, rnd(), rnd());
    c0 = consumed;
`ifdef LANE_ADDER_STAT_EN
    g0 = group_count;
`endif
    enable = 0;
    out_ready = 1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || consumed != c0) begin
        bad++;
        $display("FAIL enable_freeze got v=%b r=%b c=%0d need 1/0/%0d", out_valid, in_ready, consumed, c0);
      end
`ifdef LANE_ADDER_STAT_EN
      total++;
      if (group_count !== g0) begin
        bad++;
        $display("FAIL count_frozen got %0d need %0d", group_count, g0);
      end
`endif
    end
    @(posedge clk);
    #1;
    enable = 1;
    idle(1);
    total++;
    if (out_valid !== 1'b0 || consumed != c0 + 1) begin
      bad++;
      $display("FAIL enable_resume got v=%b c=%0d need 0/%0d", out_valid, consumed, c0 + 1);
    end
`ifdef LANE_ADDER_STAT_EN
    total++;
    if (group_count !== g0 + 16'd1) begin
      bad++;
      $display("FAIL count_inc got %0d need %0d", group_count, g0 + 16'd1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pass();
    test_accumulate();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_enable();
    idle(3);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending need 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
